// File: rtl/mci_arbiter2_pkg.sv
// Shared memory-controller types: request/response records and the client identifier
// used by the two-client arbiter.
package memory_controller_interface;

  localparam int MCI_ADDR_W = 32;
  localparam int MCI_DATA_W = 128;

  typedef enum logic {
    MCI_CLIENT_ICACHE = 1'b0,
    MCI_CLIENT_DCACHE = 1'b1
  } mci_client_t;

  typedef struct packed {
    logic [MCI_ADDR_W-1:0] addr;
    logic [MCI_DATA_W-1:0] data;
    logic                  rw;
    logic                  valid;
  } mci_request_t;

  typedef struct packed {
    logic [MCI_DATA_W-1:0] data;
    logic                  ready;
  } mci_response_t;

  function automatic mci_client_t mci_other(input mci_client_t c);
    return (c == MCI_CLIENT_ICACHE) ? MCI_CLIENT_DCACHE : MCI_CLIENT_ICACHE;
  endfunction

endpackage

// File: rtl/mci_arbiter2_if.sv
// One memory-controller port: request towards the slave, response back to the master.
interface mci_arbiter2_if;
  import memory_controller_interface::*;

  mci_request_t  req;
  mci_response_t res;

  modport master (output req, input res);
  modport slave  (input req, output res);
endinterface

// File: rtl/mci_arbiter2_slot.sv
// Single-entry request holder for one client. A capture coinciding with a clear
// reloads the slot, so a follow-on request issued on the response cycle is never lost.
module mci_req_slot
  import memory_controller_interface::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic         clear,
  input  mci_request_t req_in,
  output mci_request_t req_out,
  output logic         pending
);
  logic                  pending_reg;
  logic [MCI_ADDR_W-1:0] addr_reg;
  logic [MCI_DATA_W-1:0] data_reg;
  logic                  rw_reg;
  logic                  load;

  // An overrunning request (slot busy, not being freed) is dropped.
  assign load = capture && (!pending_reg || clear);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
      rw_reg      <= 1'b0;
    end else begin
      if (load) begin
        addr_reg <= req_in.addr;
        data_reg <= req_in.data;
        rw_reg   <= req_in.rw;
      end
      pending_reg <= load || (pending_reg && !clear);
    end
  end

  assign pending = pending_reg;
  assign req_out = '{addr: addr_reg, data: data_reg, rw: rw_reg, valid: pending_reg};

  a_no_overrun: assert property (@(posedge clk) disable iff (rst)
    !(capture && pending_reg && !clear))
    else $error("mci_req_slot: request while slot busy, dropped");

  a_capture_valid: assert property (@(posedge clk) disable iff (rst)
    capture |-> req_in.valid)
    else $error("mci_req_slot: capture without valid request");
endmodule

// File: rtl/mci_arbiter2.sv
// Round-robin arbiter: icache (c0) and dcache (c1) share one memory-controller port,
// one transaction outstanding. Define MCI_ARB_BYPASS_EN to let an idle arbiter forward
// a fresh request to memory in the same cycle instead of issuing it from the slot.
module mci_arbiter2
  import memory_controller_interface::*;
#(
  parameter mci_client_t FIRST_GRANT = MCI_CLIENT_DCACHE
) (
  input logic            clk,
  input logic            rst,
  mci_arbiter2_if.slave  c0,
  mci_arbiter2_if.slave  c1,
  mci_arbiter2_if.master mem
);
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} arb_state_t;

  arb_state_t   state_reg, state_next;
  mci_client_t  grant_reg, grant_next;
  mci_client_t  last_grant_reg, last_grant_next;
  mci_client_t  winner;
  mci_request_t client_req [2];
  mci_request_t slot_req [2];
  mci_request_t sel_req, mem_out;
  logic         slot_pending [2];
  logic         slot_clear [2];
  logic         cand [2];
  logic         resp_fire;

  assign client_req[0] = c0.req;
  assign client_req[1] = c1.req;
  assign resp_fire     = (state_reg == WAIT) && mem.res.ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_client
      assign slot_clear[gi] = resp_fire &&
        (grant_reg == ((gi == 1) ? MCI_CLIENT_DCACHE : MCI_CLIENT_ICACHE));
`ifdef MCI_ARB_BYPASS_EN
      assign cand[gi] = slot_pending[gi] || client_req[gi].valid;
`else
      assign cand[gi] = slot_pending[gi];
`endif
      mci_req_slot u_slot (
        .clk     (clk),
        .rst     (rst),
        .capture (client_req[gi].valid),
        .clear   (slot_clear[gi]),
        .req_in  (client_req[gi]),
        .req_out (slot_req[gi]),
        .pending (slot_pending[gi])
      );
    end
  endgenerate

  always_comb begin
    if (cand[0] && cand[1]) winner = mci_other(last_grant_reg);
    else if (cand[1])       winner = MCI_CLIENT_DCACHE;
    else                    winner = MCI_CLIENT_ICACHE;
  end

  always_comb begin
    sel_req = (winner == MCI_CLIENT_DCACHE) ? slot_req[1] : slot_req[0];
`ifdef MCI_ARB_BYPASS_EN
    // Empty slot but a live request: forward the client's bus directly.
    if (winner == MCI_CLIENT_DCACHE && !slot_pending[1]) sel_req = client_req[1];
    if (winner == MCI_CLIENT_ICACHE && !slot_pending[0]) sel_req = client_req[0];
`endif
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    mem_out         = '0;
    case (state_reg)
      IDLE: begin
        if (cand[0] || cand[1]) begin
          mem_out       = sel_req;
          mem_out.valid = 1'b1;
          grant_next    = winner;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        mem_out       = (grant_reg == MCI_CLIENT_DCACHE) ? slot_req[1] : slot_req[0];
        mem_out.valid = 1'b0;
        if (mem.res.ready) begin
          last_grant_next = grant_reg;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= MCI_CLIENT_ICACHE;
      last_grant_reg <= mci_other(FIRST_GRANT);
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  assign mem.req = mem_out;
  assign c0.res  = '{data: mem.res.data, ready: resp_fire && (grant_reg == MCI_CLIENT_ICACHE)};
  assign c1.res  = '{data: mem.res.data, ready: resp_fire && (grant_reg == MCI_CLIENT_DCACHE)};
endmodule
